// File: rtl/proc_pkg.sv
// Shared definitions for the simple processor: opcodes, timestep codes,
// the latched instruction layout and the bus width.
package proc_pkg;

    localparam int DATA_W = 10;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_COPY = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } opcode_t;

    typedef logic [1:0] step_t;

    localparam step_t T0 = 2'd0;
    localparam step_t T1 = 2'd1;
    localparam step_t T2 = 2'd2;
    localparam step_t T3 = 2'd3;

    typedef struct packed {
        opcode_t    op;
        logic [1:0] rx;
        logic [1:0] ry;
    } ir_t;

endpackage

// File: rtl/upcount2.sv
// Two-bit up counter with synchronous active-low reset, enable and
// synchronous clear (clear wins over enable).
module upcount2 (
    input  logic       clk,
    input  logic       rstb,
    input  logic       en,
    input  logic       clr,
    output logic [1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstb) begin
            q <= 2'd0;
        end else if (clr) begin
            q <= 2'd0;
        end else if (en) begin
            q <= q + 2'd1;
        end
    end

endmodule

// File: rtl/controller.sv
// Multi-cycle control unit: latches an instruction in T0 and sequences the
// bus, register-file and ALU strobes, decoded from the timestep and IR only.
module controller
    import proc_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTb,
    input  logic [9:0] INSTR,
    input  logic       EXEC,
    output logic [1:0] TIME,
    output logic       DONE,
    output logic       EXT_OE,
    output logic       RF_OE,
    output logic [1:0] RF_RADDR,
    output logic       RF_WE,
    output logic [1:0] RF_WADDR,
    output logic       A_LD,
    output logic       G_LD,
    output logic       G_OE,
    output logic       ALU_OP
);

    ir_t  ir;
    logic cnt_en;
    logic cnt_clr;

    // INSTR[3:0] carries no meaning for this instruction set.
    logic unused_instr;
    assign unused_instr = ^INSTR[3:0];

    // EXEC only matters while idle; once running the counter free-runs until DONE.
    assign cnt_en  = (TIME != T0) || EXEC;
    assign cnt_clr = DONE;

    upcount2 u_step (
        .clk  (CLK),
        .rstb (RSTb),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .q    (TIME)
    );

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            ir <= '0;
        end else if (TIME == T0 && EXEC) begin
            ir <= ir_t'(INSTR[9:4]);
        end
    end

    always_comb begin
        DONE     = 1'b0;
        EXT_OE   = 1'b0;
        RF_OE    = 1'b0;
        RF_RADDR = 2'b00;
        RF_WE    = 1'b0;
        RF_WADDR = 2'b00;
        A_LD     = 1'b0;
        G_LD     = 1'b0;
        G_OE     = 1'b0;
        ALU_OP   = 1'b0;
        case (TIME)
            T1: begin
                case (ir.op)
                    OP_LOAD: begin
                        EXT_OE   = 1'b1;
                        RF_WE    = 1'b1;
                        RF_WADDR = ir.rx;
                        DONE     = 1'b1;
                    end
                    OP_COPY: begin
                        RF_OE    = 1'b1;
                        RF_RADDR = ir.ry;
                        RF_WE    = 1'b1;
                        RF_WADDR = ir.rx;
                        DONE     = 1'b1;
                    end
                    default: begin
                        RF_OE    = 1'b1;
                        RF_RADDR = ir.rx;
                        A_LD     = 1'b1;
                    end
                endcase
            end
            T2: begin
                if (ir.op[1]) begin
                    RF_OE    = 1'b1;
                    RF_RADDR = ir.ry;
                    G_LD     = 1'b1;
                    ALU_OP   = ir.op[0];
                end
            end
            T3: begin
                if (ir.op[1]) begin
                    G_OE     = 1'b1;
                    RF_WE    = 1'b1;
                    RF_WADDR = ir.rx;
                    DONE     = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controller.sv
// Bench for controller: a small datapath driven by the control strobes, plus
// an instruction-level register model and per-cycle bus/DONE properties.
module tb_controller;

    logic       CLK;
    logic       RSTb;
    logic [9:0] INSTR;
    logic       EXEC;
    logic [1:0] TIME;
    logic       DONE, EXT_OE, RF_OE, RF_WE, A_LD, G_LD, G_OE, ALU_OP;
    logic [1:0] RF_RADDR, RF_WADDR;

    int checks = 0;
    int errors = 0;

    controller dut (
        .CLK(CLK), .RSTb(RSTb), .INSTR(INSTR), .EXEC(EXEC), .TIME(TIME),
        .DONE(DONE), .EXT_OE(EXT_OE), .RF_OE(RF_OE), .RF_RADDR(RF_RADDR),
        .RF_WE(RF_WE), .RF_WADDR(RF_WADDR), .A_LD(A_LD), .G_LD(G_LD),
        .G_OE(G_OE), .ALU_OP(ALU_OP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Datapath driven by the controller's strobes.
    logic [9:0] ext_data;
    logic [9:0] dp_rf [4];
    logic [9:0] dp_a, dp_g, bus;

    always_comb begin
        bus = 10'd0;
        if (EXT_OE)     bus = ext_data;
        else if (RF_OE) bus = dp_rf[RF_RADDR];
        else if (G_OE)  bus = dp_g;
    end

    always @(posedge CLK) begin
        if (RF_WE) dp_rf[RF_WADDR] <= bus;
        if (A_LD)  dp_a <= bus;
        if (G_LD)  dp_g <= ALU_OP ? dp_a - bus : dp_a + bus;
    end

    // Instruction-level reference: registers as plain integers mod 1024.
    int model_rf [4];

    task automatic model_exec(input int op, input int rx, input int ry, input int ext);
        case (op)
            0: model_rf[rx] = ext % 1024;
            1: model_rf[rx] = model_rf[ry];
            2: model_rf[rx] = (model_rf[rx] + model_rf[ry]) % 1024;
            default: model_rf[rx] = (model_rf[rx] - model_rf[ry] + 1024) % 1024;
        endcase
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ctrl_now();
        return int'({DONE, EXT_OE, RF_OE, RF_RADDR, RF_WE, RF_WADDR, A_LD, G_LD, G_OE, ALU_OP});
    endfunction

    function automatic int ctrl_exp(input bit done, input bit ext, input bit rfoe,
                                    input int raddr, input bit we, input int waddr,
                                    input bit ald, input bit gld, input bit goe, input bit aop);
        logic [1:0] ra, wa;
        ra = raddr[1:0];
        wa = waddr[1:0];
        return int'({done, ext, rfoe, ra, we, wa, ald, gld, goe, aop});
    endfunction

    function automatic int reg_at(input int i);
        return int'(dp_rf[i]);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) check(tag, reg_at(i), model_rf[i]);
    endtask

    // Runs one instruction, checks its latency and the resulting register file.
    task automatic run_instr(input int op, input int rx, input int ry, input int ext,
                             input bit hold, input bit scramble);
        int lat;
        logic [3:0] junk;
        junk = 4'($urandom);
        INSTR = {op[1:0], rx[1:0], ry[1:0], junk};
        ext_data = ext[9:0];
        EXEC = 1'b1;
        tick();
        lat = 1;
        if (!hold) EXEC = 1'b0;
        while (!DONE && lat < 6) begin
            if (scramble) INSTR = 10'($urandom);
            tick();
            lat++;
        end
        check("latency", lat, (op < 2) ? 1 : 3);
        model_exec(op, rx, ry, ext);
        tick();
        check("idle_after_done", int'(TIME), 0);
        check_regs("regfile");
    endtask

    // Properties watched on every cycle, sampled away from the active edge.
    always @(negedge CLK) begin
        checks++;
        assert ($onehot0({EXT_OE, RF_OE, G_OE})) else begin
            errors++;
            $error("FAIL bus_onehot0: observed %b expected at most one set", {EXT_OE, RF_OE, G_OE});
        end
        checks++;
        assert (!DONE || TIME == 2'd1 || TIME == 2'd3) else begin
            errors++;
            $error("FAIL done_step: observed TIME %0d with DONE expected TIME 1 or 3", TIME);
        end
        checks++;
        assert (TIME != 2'd0 || {DONE, EXT_OE, RF_OE, RF_WE, A_LD, G_LD, G_OE, ALU_OP, RF_RADDR, RF_WADDR} == '0) else begin
            errors++;
            $error("FAIL t0_quiet: observed outputs active in T0 expected all zero");
        end
    end

    initial begin
        int saved;
        RSTb = 1'b0;
        EXEC = 1'b1;
        INSTR = 10'b10_01_10_0000;
        ext_data = 10'd0;
        tick();
        tick();
        check("reset_time_exec_high", int'(TIME), 0);
        check("reset_outputs", ctrl_now(), 0);
        RSTb = 1'b1;
        EXEC = 1'b0;
        tick();
        check("idle_time", int'(TIME), 0);

        for (int i = 0; i < 4; i++) run_instr(0, i, 0, int'($urandom_range(0, 1023)), 1'b0, 1'b0);

        // LOAD R2
        INSTR = 10'b00_10_00_0000;
        ext_data = 10'h2A5;
        EXEC = 1'b1;
        tick();
        EXEC = 1'b0;
        check("load_time", int'(TIME), 1);
        check("load_ctrl", ctrl_now(), ctrl_exp(1, 1, 0, 0, 1, 2, 0, 0, 0, 0));
        tick();
        model_exec(0, 2, 0, 'h2A5);
        check("load_back_t0", int'(TIME), 0);
        check("load_r2", reg_at(2), 'h2A5);

        // COPY R1 <- R3
        INSTR = 10'b01_01_11_0000;
        EXEC = 1'b1;
        tick();
        EXEC = 1'b0;
        check("copy_time", int'(TIME), 1);
        check("copy_ctrl", ctrl_now(), ctrl_exp(1, 0, 1, 3, 1, 1, 0, 0, 0, 0));
        tick();
        model_exec(1, 1, 3, 0);
        check_regs("copy_regs");

        // ADD R0 <- R0 + R1, with INSTR changing after acceptance
        run_instr(0, 0, 0, 5, 1'b0, 1'b0);
        run_instr(0, 1, 0, 7, 1'b0, 1'b0);
        INSTR = 10'b10_00_01_0000;
        EXEC = 1'b1;
        tick();
        EXEC = 1'b0;
        INSTR = 10'b11_11_11_1111;
        check("add_t1", ctrl_now(), ctrl_exp(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        tick();
        check("add_t2_time", int'(TIME), 2);
        check("add_t2", ctrl_now(), ctrl_exp(0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
        tick();
        check("add_t3", ctrl_now(), ctrl_exp(1, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        tick();
        model_exec(2, 0, 1, 0);
        check("add_r0", reg_at(0), 12);

        // SUB R2 <- R2 - R3 with EXEC held high throughout
        run_instr(0, 2, 0, 3, 1'b0, 1'b0);
        run_instr(0, 3, 0, 5, 1'b0, 1'b0);
        INSTR = 10'b11_10_11_0000;
        EXEC = 1'b1;
        tick();
        check("sub_t1_time", int'(TIME), 1);
        tick();
        check("sub_t2_time", int'(TIME), 2);
        check("sub_t2", ctrl_now(), ctrl_exp(0, 0, 1, 3, 0, 0, 0, 1, 0, 1));
        tick();
        check("sub_t3_time", int'(TIME), 3);
        check("sub_done", int'(DONE), 1);
        INSTR = 10'b00_00_00_0000;
        ext_data = 10'd99;
        tick();
        model_exec(3, 2, 3, 0);
        check("sub_back_t0", int'(TIME), 0);
        check("sub_r2_wrap", reg_at(2), 1022);
        tick();
        check("restart_time", int'(TIME), 1);
        check("restart_load", ctrl_now(), ctrl_exp(1, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        EXEC = 1'b0;
        tick();
        model_exec(0, 0, 0, 99);
        check_regs("restart_regs");

        // Reset during T2 of ADD R3 <- R3 + R0
        saved = reg_at(3);
        INSTR = 10'b10_11_00_0000;
        EXEC = 1'b1;
        tick();
        EXEC = 1'b0;
        tick();
        check("abort_at_t2", int'(TIME), 2);
        RSTb = 1'b0;
        tick();
        RSTb = 1'b1;
        check("abort_time", int'(TIME), 0);
        check("abort_outputs", ctrl_now(), 0);
        tick();
        tick();
        check("abort_time_idle", int'(TIME), 0);
        check("abort_r3_kept", reg_at(3), saved);

        // Random instruction streams
        for (int n = 0; n < 80; n++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
                      1'($urandom), 1'($urandom));
        end
        EXEC = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RSTb, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port INSTR, input, 10 bits: instruction from the switches; [9:8]=OP, [7:6]=RX, [5:4]=RY, [3:0] ignored.
REQ-004 SHALL have port EXEC, input, 1 bit: start request, sampled each cycle, already synchronised.
REQ-005 SHALL have port TIME, output, 2 bits: current timestep T0..T3, fed to the display.
REQ-006 SHALL have port DONE, output, 1 bit: high during the final step of an instruction.
REQ-007 SHALL have port EXT_OE, output, 1 bit: drives the external data onto the shared bus.
REQ-008 SHALL have port RF_OE, output, 1 bit: drives register file read data onto the bus.
REQ-009 SHALL have port RF_RADDR, output, 2 bits: register file read address.
REQ-010 SHALL have port RF_WE, output, 1 bit: register file write enable; the bus is written at the clock edge.
REQ-011 SHALL have port RF_WADDR, output, 2 bits: register file write address.
REQ-012 SHALL have port A_LD, output, 1 bit: loads the ALU operand register A from the bus.
REQ-013 SHALL have port G_LD, output, 1 bit: loads the ALU result register G.
REQ-014 SHALL have port G_OE, output, 1 bit: drives G onto the bus.
REQ-015 SHALL have port ALU_OP, output, 1 bit: 0 selects A+bus and 1 selects A-bus, each modulo 2^10.

Function
REQ-016 SHALL hold the opcode encodings 00 LOAD, 01 COPY, 10 ADD, 11 SUB.
REQ-017 SHALL keep T0 as the idle step; when EXEC=1 in T0, SHALL latch INSTR[9:4] into IR and advance TIME to 1.
REQ-018 SHALL ignore EXEC in T1..T3 and SHALL ignore INSTR changes after it latches IR.
REQ-019 SHALL execute LOAD in T1: EXT_OE=1, RF_WE=1, RF_WADDR=RX, DONE=1; TIME then returns to 0.
REQ-020 SHALL execute COPY in T1: RF_OE=1, RF_RADDR=RY, RF_WE=1, RF_WADDR=RX, DONE=1; TIME then returns to 0.
REQ-021 SHALL execute ADD/SUB in T1 as RF_OE=1, RF_RADDR=RX, A_LD=1.
REQ-022 SHALL execute ADD/SUB in T2 as RF_OE=1, RF_RADDR=RY, G_LD=1, ALU_OP=OP[0].
REQ-023 SHALL execute ADD/SUB in T3 as G_OE=1, RF_WE=1, RF_WADDR=RX, DONE=1; TIME then returns to 0.
REQ-024 SHALL decode all control outputs combinationally from TIME and IR (Moore-style); EXEC and INSTR SHALL NOT reach the outputs combinationally.
REQ-025 SHALL keep the latency from EXEC accepted to the DONE cycle at 1 cycle for LOAD/COPY and 3 cycles for ADD/SUB.
REQ-026 SHALL allow a new instruction to start on the cycle after DONE, with no dead cycle beyond T0 sampling.
REQ-027 SHALL assert at most one of EXT_OE, RF_OE, G_OE in any cycle.
REQ-028 SHALL keep every control output 0 in T0 and drive RF_RADDR/RF_WADDR to 00 when they are unused.
REQ-029 SHALL allow RX=RY; for SUB the result is then 0, and no special handling is required.

Reset
REQ-030 SHALL, when RSTb=0 at a clock edge, set TIME=0, IR=0, and all outputs to 0 on the next cycle, whatever step is in progress.
REQ-031 SHALL, if reset interrupts T1..T3, issue no register write after reset and discard the instruction.
REQ-032 SHALL take no reset precedence from EXEC: RSTb=0 with EXEC=1 leaves TIME=0.

Structure
REQ-033 SHALL define the opcode enum, the timestep constants T0..T3 and the bus/data width (10) in shared package proc_pkg.
REQ-034 SHALL implement the timestep counter as sub-module upcount2 (2-bit counter with synchronous active-low reset, enable and synchronous clear); the decode logic stays in the controller.

Verification
REQ-035 SHALL cover: reset, then EXEC with INSTR=00_10_00_0000 (LOAD R2) -> next cycle TIME=1, EXT_OE=1, RF_WE=1, RF_WADDR=10, DONE=1; then TIME=0.
REQ-036 SHALL cover: COPY R1<-R3 (INSTR=01_01_11_0000) -> T1: RF_OE=1, RF_RADDR=11, RF_WADDR=01, RF_WE=1, DONE=1.
REQ-037 SHALL cover: ADD R0<-R0+R1 with R0=5, R1=7 in a datapath model -> T1 A_LD, RADDR=00; T2 G_LD, RADDR=01, ALU_OP=0; T3 G_OE, WE, DONE; R0=12.
REQ-038 SHALL cover: SUB R2<-R2-R3 with R2=3, R3=5 -> R2=1022 (wrap-around); EXEC held high throughout is ignored in T1..T3 and starts the next instruction in T0.
REQ-039 SHALL cover: RSTb=0 during T2 of ADD -> next cycle TIME=0, all outputs 0, and the target register is unchanged.
REQ-040 SHALL cover: an assertion checked every cycle of random instruction streams -> onehot0 of {EXT_OE, RF_OE, G_OE}; DONE only when TIME is 1 or 3.
